// File: rtl/prefetch_queue_if.sv
// Bus bundle for prefetch_queue: instruction-memory port, redirect input
// and the decode-facing queue head. The master modport is the queue side.
interface prefetch_queue_if #(
  parameter int XLEN  = 32,
  parameter int DEPTH = 4
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic              mem_request;
  logic              mem_we_re;
  logic [XLEN/8-1:0] mem_mask;
  logic [XLEN-1:0]   mem_addr;
  logic              mem_valid;
  logic [XLEN-1:0]   mem_rdata;
  logic              redirect;
  logic [XLEN-1:0]   redirect_addr;
  logic              out_ready;
  logic              out_valid;
  logic [XLEN-1:0]   out_instr;
  logic [XLEN-1:0]   out_pc;
  logic [CW-1:0]     occupancy;

  modport master (
    output mem_request, mem_we_re, mem_mask, mem_addr,
    input  mem_valid, mem_rdata,
    input  redirect, redirect_addr,
    input  out_ready,
    output out_valid, out_instr, out_pc, occupancy
  );

  modport slave (
    input  mem_request, mem_we_re, mem_mask, mem_addr,
    output mem_valid, mem_rdata,
    output redirect, redirect_addr,
    output out_ready,
    input  out_valid, out_instr, out_pc, occupancy
  );
endinterface

// File: rtl/prefetch_queue.sv
// Instruction prefetch queue: fetches sequential words into a DEPTH-entry
// FIFO with a single outstanding memory request, flushing on redirect.
// Optional macro PREFETCH_BYPASS_EN: an accepted response is forwarded
// straight to the head outputs when the queue is empty and decode is ready.
module prefetch_queue #(
  parameter int              XLEN     = 32,
  parameter int              DEPTH    = 4,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst,
  prefetch_queue_if.master  bus
);
  localparam int            AW   = $clog2(DEPTH);
  localparam int            CW   = AW + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  typedef enum logic [1:0] {IDLE, WAIT, DROP} state_t;

  state_t          state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;      // next address to fetch (restart PC in DROP)
  logic [XLEN-1:0] addr_q, addr_d;  // address presented on the bus
  logic [AW-1:0]   rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [XLEN-1:0] pc_mem    [DEPTH];
  logic [XLEN-1:0] instr_mem [DEPTH];

  logic [XLEN-1:0] redir_pc;
  logic            accept, byp, push, pop;

  assign redir_pc = bus.redirect_addr & ~XLEN'(3);
  assign accept   = (state_q == WAIT) && bus.mem_valid && !bus.redirect;
`ifdef PREFETCH_BYPASS_EN
  assign byp      = accept && (cnt_q == '0) && bus.out_ready;
`else
  assign byp      = 1'b0;
`endif
  assign push     = accept && !byp;
  assign pop      = (cnt_q != '0) && bus.out_ready && !bus.redirect;

  // Queue bookkeeping: redirect empties the queue and overrides any pop.
  always_comb begin
    cnt_d    = cnt_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    if (bus.redirect) begin
      cnt_d    = '0;
      rd_ptr_d = '0;
      wr_ptr_d = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
      cnt_d = cnt_q + CW'(push) - CW'(pop);
    end
  end

  // Fetch FSM: a new request only starts when the post-cycle queue has room.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    unique case (state_q)
      IDLE: begin
        if (bus.redirect) pc_d = redir_pc;
        if (cnt_d < FULL) state_d = WAIT;
      end
      WAIT: begin
        if (bus.redirect) begin
          pc_d    = redir_pc;
          state_d = bus.mem_valid ? WAIT : DROP;
        end else if (bus.mem_valid) begin
          pc_d    = pc_q + XLEN'(4);
          state_d = (cnt_d < FULL) ? WAIT : IDLE;
        end
      end
      DROP: begin
        if (bus.redirect)  pc_d    = redir_pc;
        if (bus.mem_valid) state_d = WAIT;
      end
      default: state_d = IDLE;
    endcase
    // The stale request keeps its address until its response is discarded.
    addr_d = (state_d == DROP) ? addr_q : pc_d;
  end

  // Control state with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= IDLE;
      pc_q     <= RESET_PC;
      addr_q   <= RESET_PC;
      cnt_q    <= '0;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      addr_q   <= addr_d;
      cnt_q    <= cnt_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
    end
  end

  // Entry storage; contents are qualified by the count so no reset needed.
  always_ff @(posedge clk) begin
    if (push) begin
      pc_mem[wr_ptr_q]    <= addr_q;
      instr_mem[wr_ptr_q] <= bus.mem_rdata;
    end
  end

  assign bus.mem_request = (state_q != IDLE);
  assign bus.mem_we_re   = 1'b0;
  assign bus.mem_mask    = '1;
  assign bus.mem_addr    = addr_q;
  assign bus.occupancy   = cnt_q;
  assign bus.out_valid   = (cnt_q != '0) || byp;
  assign bus.out_instr   = byp ? bus.mem_rdata : instr_mem[rd_ptr_q];
  assign bus.out_pc      = byp ? addr_q        : pc_mem[rd_ptr_q];
endmodule

// File: tb/tb_prefetch_queue.sv
// Scoreboard bench for prefetch_queue: accepted responses are queued as
// expected {pc, instr} and compared against the head when decode pops.
module tb_prefetch_queue;
  localparam int          XLEN     = 32;
  localparam int          DEPTH    = 4;
  localparam logic [31:0] RESET_PC = 32'h0;

  logic clk = 1'b0;
  logic rst = 1'b0;

  prefetch_queue_if #(.XLEN(XLEN), .DEPTH(DEPTH)) bus ();

  prefetch_queue #(.XLEN(XLEN), .DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } ent_t;

  ent_t        sb[$];
  int          n_cmp = 0;
  int          n_bad = 0;
  logic [31:0] exp_pc = RESET_PC;
  bit          drop = 1'b0;
  bit          mem_en = 1'b0;
  bit          mon_acc, mon_byp;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] data_of(input logic [31:0] a);
    return {a[15:0] ^ 16'hBEEF, a[15:0]};
  endfunction

  // Advance one cycle; the memory model answers any open request at once.
  task automatic tick();
    @(posedge clk); #1;
    if (mem_en && bus.mem_request) begin
      bus.mem_valid = 1'b1;
      bus.mem_rdata = data_of(bus.mem_addr);
    end else begin
      bus.mem_valid = 1'b0;
    end
  endtask

  // Monitor: checks head/occupancy each cycle and maintains the scoreboard.
  always @(negedge clk) begin
    if (!rst) begin
      sb.delete();
      exp_pc = RESET_PC;
      drop   = 1'b0;
    end else begin
      mon_acc = bus.mem_request && bus.mem_valid && !bus.redirect && !drop;
      mon_byp = 1'b0;
`ifdef PREFETCH_BYPASS_EN
      mon_byp = mon_acc && (sb.size() == 0) && bus.out_ready;
`endif
      chk("occupancy", bus.occupancy, sb.size());
      chk("out_valid", bus.out_valid, (sb.size() != 0) || mon_byp);
      if (mon_byp) begin
        chk("byp_pc", bus.out_pc, exp_pc);
        chk("byp_instr", bus.out_instr, bus.mem_rdata);
      end else if (sb.size() != 0) begin
        chk("head_pc", bus.out_pc, sb[0].pc);
        chk("head_instr", bus.out_instr, sb[0].instr);
        if (bus.out_ready && !bus.redirect) void'(sb.pop_front());
      end
      if (mon_acc) begin
        chk("fetch_addr", bus.mem_addr, exp_pc);
        if (!mon_byp) sb.push_back({exp_pc, bus.mem_rdata});
        exp_pc = exp_pc + 32'd4;
      end
      if (bus.redirect) begin
        sb.delete();
        exp_pc = bus.redirect_addr & ~32'h3;
        if (bus.mem_request) drop = !bus.mem_valid;
      end else if (bus.mem_request && bus.mem_valid && drop) begin
        drop = 1'b0;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    bus.mem_valid     = 1'b0;
    bus.mem_rdata     = '0;
    bus.redirect      = 1'b0;
    bus.redirect_addr = '0;
    bus.out_ready     = 1'b0;

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_req", bus.mem_request, 0);
    chk("rst_occ", bus.occupancy, 0);
    chk("rst_ovld", bus.out_valid, 0);
    chk("rst_addr", bus.mem_addr, RESET_PC);
    @(posedge clk); #1;
    rst    = 1'b1;
    mem_en = 1'b1;

    // First request right after release, then fill to full and stop
    tick();
    chk("first_req", bus.mem_request, 1);
    chk("first_addr", bus.mem_addr, RESET_PC);
    for (int i = 0; i < 20 && int'(bus.occupancy) != DEPTH; i++) tick();
    chk("fill_occ", bus.occupancy, DEPTH);
    chk("fill_idle", bus.mem_request, 0);

    // One pop from a full queue -> exactly one refill at 16
    bus.out_ready = 1'b1;
    @(negedge clk);
    chk("pop_pc", bus.out_pc, 0);
    tick();
    bus.out_ready = 1'b0;
    chk("refill_req", bus.mem_request, 1);
    chk("refill_addr", bus.mem_addr, 16);
    tick();
    chk("refill_occ", bus.occupancy, DEPTH);
    chk("refill_idle", bus.mem_request, 0);

    // Streaming with decode ready
    bus.out_ready = 1'b1;
    repeat (6) tick();

    // Redirect coinciding with a response: data discarded, restart at target
    chk("pre_redir_req", bus.mem_request, 1);
    bus.mem_valid     = 1'b1;
    bus.redirect      = 1'b1;
    bus.redirect_addr = 32'h40;
    tick();
    bus.redirect = 1'b0;
    chk("redir_same_addr", bus.mem_addr, 32'h40);
    chk("redir_same_occ", bus.occupancy, 0);

    // Restart at 0, then redirect while waiting at 0x8 with a late response
    bus.redirect      = 1'b1;
    bus.redirect_addr = 32'h0;
    tick();
    bus.redirect = 1'b0;
    for (int i = 0; i < 20 && !(bus.mem_request && bus.mem_addr == 32'h8); i++) tick();
    mem_en        = 1'b0;
    bus.mem_valid = 1'b0;
    chk("reach_8", bus.mem_addr, 32'h8);
    bus.redirect      = 1'b1;
    bus.redirect_addr = 32'h103;
    tick();
    bus.redirect = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk("drop_req", bus.mem_request, 1);
      chk("drop_addr", bus.mem_addr, 32'h8);
      if (i < 2) tick();
    end
    mem_en = 1'b1;
    tick();
    tick();
    chk("drop_restart", bus.mem_addr, 32'h100);
    chk("drop_occ", bus.occupancy, 0);

    // Second redirect while dropping only moves the restart PC
    mem_en            = 1'b0;
    bus.mem_valid     = 1'b0;
    bus.redirect      = 1'b1;
    bus.redirect_addr = 32'h200;
    tick();
    bus.redirect_addr = 32'h300;
    tick();
    bus.redirect = 1'b0;
    chk("drop2_hold", bus.mem_addr, 32'h100);
    mem_en = 1'b1;
    tick();
    tick();
    chk("drop2_restart", bus.mem_addr, 32'h300);

    // Response into an empty queue with decode ready
    mem_en        = 1'b0;
    bus.mem_valid = 1'b0;
    repeat (3) tick();
    chk("byp_pre_occ", bus.occupancy, 0);
    bus.mem_valid = 1'b1;
    bus.mem_rdata = 32'h0000_0013;
    @(negedge clk);
`ifdef PREFETCH_BYPASS_EN
    chk("byp_ovld", bus.out_valid, 1);
    chk("byp_instr0", bus.out_instr, 32'h13);
    chk("byp_occ0", bus.occupancy, 0);
    tick();
    chk("byp_occ1", bus.occupancy, 0);
`else
    chk("nobyp_ovld0", bus.out_valid, 0);
    tick();
    chk("nobyp_ovld1", bus.out_valid, 1);
    chk("nobyp_instr1", bus.out_instr, 32'h13);
    chk("nobyp_occ1", bus.occupancy, 1);
`endif

    // Asynchronous reset in the middle of a request
    bus.out_ready = 1'b0;
    mem_en        = 1'b1;
    repeat (2) tick();
    mem_en = 1'b0;
    tick();
    chk("pre_rst_req", bus.mem_request, 1);
    chk("pre_rst_ovld", bus.out_valid, 1);
    bus.mem_valid = 1'b1;
    rst = 1'b0;
    #1;
    chk("arst_req", bus.mem_request, 0);
    chk("arst_ovld", bus.out_valid, 0);
    chk("arst_occ", bus.occupancy, 0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    bus.mem_valid = 1'b0;
    chk("post_rst_req", bus.mem_request, 1);
    chk("post_rst_addr", bus.mem_addr, RESET_PC);
    chk("post_rst_occ", bus.occupancy, 0);

    // Free run to exercise pointer wrap
    mem_en        = 1'b1;
    bus.out_ready = 1'b1;
    repeat (10) tick();
    bus.out_ready = 1'b0;
    repeat (6) tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/prefetch_queue.md
PREFETCH_QUEUE -- requirements
Module: prefetch_queue

Interface
REQ-001 SHALL have parameter XLEN, default 32, address/instruction width.
REQ-002 SHALL have parameter DEPTH, default 4, queue entries (power of two, >=2).
REQ-003 SHALL have parameter RESET_PC, default 0, first fetch address after reset.
REQ-004 SHALL have ports:
- clk  in  1  clock, all state on rising edge.
- rst  in  1  asynchronous, active-low reset.
- mem_request  out  1  instruction-memory read request.
- mem_we_re  out  1  constant 0 (read).
- mem_mask  out  XLEN/8  constant all-ones.
- mem_addr  out  XLEN  fetch address, word-aligned.
- mem_valid  in  1  response strobe for the outstanding request.
- mem_rdata  in  XLEN  fetched instruction.
- redirect  in  1  flush and restart fetch (branch/jump taken).
- redirect_addr  in  XLEN  new fetch PC.
- out_ready  in  1  decode accepts the head entry (low = stall, e.g. load).
- out_valid  out  1  head entry valid.
- out_instr  out  XLEN  head instruction.
- out_pc  out  XLEN  PC of head instruction.
- occupancy  out  clog2(DEPTH)+1  entries held.

Function
REQ-005 SHALL hold at most one outstanding memory request at any time.
REQ-006 SHALL keep mem_addr stable while mem_request is high and the response has not arrived.
REQ-007 SHALL use FSM states IDLE, WAIT, DROP; mem_request = (state != IDLE).
REQ-008 IDLE->WAIT SHALL occur when the post-cycle occupancy is < DEPTH; mem_addr = fetch PC.
REQ-009 In WAIT with mem_valid and no redirect, SHALL push {fetch PC, mem_rdata}, advance PC by 4 (modulo 2^XLEN), and stay WAIT at the new address if a free entry remains after that cycle's push/pop, else go IDLE.
REQ-010 In WAIT with redirect and no mem_valid, SHALL go DROP, holding mem_request and the old mem_addr.
REQ-011 In DROP, SHALL discard the response on mem_valid and go WAIT at the redirect PC.
REQ-012 In WAIT with redirect and mem_valid in the same cycle, SHALL discard the response and go WAIT at redirect_addr.
REQ-013 In IDLE with redirect, SHALL load the fetch PC from redirect_addr; the request issues per REQ-008.
REQ-014 Redirect SHALL empty the queue on the next edge, and a pop in the redirect cycle SHALL be ignored.
REQ-015 SHALL force redirect_addr[1:0] to 0.
REQ-016 out_valid SHALL be (occupancy != 0); out_instr/out_pc SHALL be the head entry.
REQ-017 Pop SHALL occur when out_valid && out_ready && !redirect.
REQ-018 Simultaneous push and pop SHALL leave occupancy unchanged, and a push into a full queue SHALL never happen.
REQ-019 Read/write pointers SHALL wrap modulo DEPTH.
REQ-020 Order SHALL be strict FIFO; a second redirect while in DROP SHALL update the restart PC without leaving DROP.

Reset
REQ-021 On rst low, SHALL asynchronously set state IDLE, occupancy 0, pointers 0, fetch PC RESET_PC, mem_request 0, out_valid 0.
REQ-022 A response arriving after reset mid-request SHALL be ignored.
REQ-023 The first request SHALL issue in the first cycle after rst deasserts, at RESET_PC.

Configuration
REQ-024 The macro PREFETCH_BYPASS_EN SHALL select bypass behaviour.
REQ-025 With PREFETCH_BYPASS_EN defined, when the queue is empty, mem_valid is accepted (WAIT, no redirect) and out_ready is high, the response SHALL appear on out_valid/out_instr/out_pc in the same cycle without being written.
REQ-026 Without PREFETCH_BYPASS_EN, responses SHALL always be written and become visible one cycle later.

Verification
REQ-027 Reset release with RESET_PC=0 and memory returning valid the next cycle SHALL produce mem_addr 0,4,8,12 and occupancy 4 (DEPTH=4, out_ready=0), then mem_request 0.
REQ-028 A full queue followed by out_ready=1 for one cycle SHALL produce out_pc 0 and one new request to address 16.
REQ-029 Redirect to 0x103 while WAIT at 0x8 with mem_valid delayed 3 cycles SHALL hold mem_addr 0x8, drop the response, then request 0x100 with occupancy 0.
REQ-030 Redirect with mem_valid in the same cycle SHALL discard that data, with the next mem_addr = redirect_addr.
REQ-031 With PREFETCH_BYPASS_EN, an empty queue, out_ready=1 and mem_rdata=0x00000013 SHALL give out_valid=1 and out_instr=0x13 in the same cycle with occupancy staying 0; without the macro, the same data SHALL appear one cycle later.
REQ-032 Asserting rst low mid-WAIT SHALL immediately drop mem_request and out_valid to 0.
